// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register-file writeback arbiter slice.
//   WIDTH     : register data width
//   AW        : register address width (2**AW registers, x0 hard-wired zero)
//   NUM_REGS  : number of architectural registers
//   reg_addr_t: register address type
//   word_t    : register data type
//   grant_idx_t: which requester last won the write port
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int WIDTH    = 32;
    localparam int AW       = 5;
    localparam int NUM_REGS = 2 ** AW;

    typedef logic [AW-1:0]    reg_addr_t;
    typedef logic [WIDTH-1:0] word_t;

    typedef enum logic {
        GRANT_REQ0 = 1'b0,
        GRANT_REQ1 = 1'b1
    } grant_idx_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   valid[1:0]  : request lines, bit N = requester N
//   last_grant  : index of the requester that won the most recent transfer
//   grant[1:0]  : one-hot grant (all zero when nobody requests)
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // A lone requester always wins; on a tie the requester that did not win
    // last time gets the port, which gives strict 0,1,0,1 alternation.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single regfile write port between an ALU writeback requester
// (req0) and a load/multicycle requester (req1) with round-robin arbitration,
// and keeps a pending-write scoreboard so decode can stall on RAW hazards.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   req0_valid/addr/data/ready : requester 0 handshake
//   req1_valid/addr/data/ready : requester 1 handshake
//   claim_valid/claim_addr     : decode marks a destination register busy
//   ra1, ra2                   : snooped regfile read addresses
//   we3, wa3, wd3              : registered regfile write port
//   hazard                     : busy[ra1] | busy[ra2]
//   busy                       : pending-write scoreboard, one bit per reg
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int WIDTH = regfile_pkg::WIDTH,
    parameter int AW    = regfile_pkg::AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic [AW-1:0]      req0_addr,
    input  logic [WIDTH-1:0]   req0_data,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [AW-1:0]      req1_addr,
    input  logic [WIDTH-1:0]   req1_data,
    output logic               req1_ready,
    input  logic               claim_valid,
    input  logic [AW-1:0]      claim_addr,
    input  logic [AW-1:0]      ra1,
    input  logic [AW-1:0]      ra2,
    output logic               we3,
    output logic [AW-1:0]      wa3,
    output logic [WIDTH-1:0]   wd3,
    output logic               hazard,
    output logic [2**AW-1:0]   busy
);

    localparam int NREGS = 2 ** AW;

    grant_idx_t         last_grant;
    logic [1:0]         grant;
    logic               xfer;
    logic [AW-1:0]      sel_addr;
    logic [WIDTH-1:0]   sel_data;
    logic [NREGS-1:0]   busy_next;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign xfer       = |grant;
    assign sel_addr   = grant[1] ? req1_addr : req0_addr;
    assign sel_data   = grant[1] ? req1_data : req0_data;

    // Register the granted write one cycle after the handshake. A transfer
    // to x0 still completes the handshake but never raises the write enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            we3        <= 1'b0;
            wa3        <= '0;
            wd3        <= '0;
            last_grant <= GRANT_REQ1;
        end else begin
            we3 <= xfer && (sel_addr != '0);
            if (xfer) begin
                wa3        <= sel_addr;
                wd3        <= sel_data;
                last_grant <= grant[1] ? GRANT_REQ1 : GRANT_REQ0;
            end
        end
    end

    // The clear for the register being written this cycle is applied first
    // so that a new claim of the same register on the same edge survives.
    always_comb begin
        busy_next = busy;
        if (we3) begin
            busy_next[wa3] = 1'b0;
        end
        if (claim_valid && (claim_addr != '0)) begin
            busy_next[claim_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // busy[0] is never set, so reads of x0 never stall decode.
    assign hazard = busy[ra1] | busy[ra2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed testbench for regfile_wb_arbiter. Inputs change 1 ns after each
// rising edge; combinational outputs are sampled 1 ns after that and
// registered outputs 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int WIDTH = 32;
    localparam int AW    = 5;

    logic               clk;
    logic               reset;
    logic               req0_valid;
    logic [AW-1:0]      req0_addr;
    logic [WIDTH-1:0]   req0_data;
    logic               req0_ready;
    logic               req1_valid;
    logic [AW-1:0]      req1_addr;
    logic [WIDTH-1:0]   req1_data;
    logic               req1_ready;
    logic               claim_valid;
    logic [AW-1:0]      claim_addr;
    logic [AW-1:0]      ra1;
    logic [AW-1:0]      ra2;
    logic               we3;
    logic [AW-1:0]      wa3;
    logic [WIDTH-1:0]   wd3;
    logic               hazard;
    logic [2**AW-1:0]   busy;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .ra1         (ra1),
        .ra2         (ra2),
        .we3         (we3),
        .wa3         (wa3),
        .wd3         (wd3),
        .hazard      (hazard),
        .busy        (busy)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid  = 1'b0;
        req0_addr   = '0;
        req0_data   = '0;
        req1_valid  = 1'b0;
        req1_addr   = '0;
        req1_data   = '0;
        claim_valid = 1'b0;
        claim_addr  = '0;
        ra1         = '0;
        ra2         = '0;
    endtask

    // Reset held two cycles with requests and a claim present must leave
    // every registered output and the scoreboard cleared.
    task automatic test_reset();
        reset       = 1'b1;
        req0_valid  = 1'b1; req0_addr = 5'd9;  req0_data = 32'h1111_1111;
        req1_valid  = 1'b1; req1_addr = 5'd10; req1_data = 32'h2222_2222;
        claim_valid = 1'b1; claim_addr = 5'd7;
        step();
        step();
        checks++;
        if (we3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_we3: got %b expected 0", we3); end
        checks++;
        if (wa3 !== 5'd0) begin errors++; $display("[TB] FAIL reset_wa3: got %0d expected 0", wa3); end
        checks++;
        if (wd3 !== 32'h0) begin errors++; $display("[TB] FAIL reset_wd3: got %h expected 0", wd3); end
        checks++;
        if (busy !== 32'h0) begin errors++; $display("[TB] FAIL reset_busy: got %h expected 0", busy); end
        idle_inputs();
        reset = 1'b0;
        step();
        checks++;
        if (we3 !== 1'b0 || busy !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_release: we3=%b busy=%h expected 0/0", we3, busy);
        end
    endtask

    // One req0 transfer: ready same cycle, write next cycle, idle after.
    task automatic test_single();
        req0_valid = 1'b1; req0_addr = 5'd2; req0_data = 32'h15;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_ready: got r0=%b r1=%b expected 1/0", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0;
        checks++;
        if (we3 !== 1'b1 || wa3 !== 5'd2 || wd3 !== 32'h15) begin
            errors++;
            $display("[TB] FAIL single_write: got we3=%b wa3=%0d wd3=%h expected 1/2/15", we3, wa3, wd3);
        end
        step();
        checks++;
        if (we3 !== 1'b0 || wa3 !== 5'd2 || wd3 !== 32'h15) begin
            errors++;
            $display("[TB] FAIL single_idle: got we3=%b wa3=%0d wd3=%h expected 0/2/15", we3, wa3, wd3);
        end
    endtask

    // Both requesters valid continuously after reset alternate 0,1,0,1.
    task automatic test_contention();
        reset = 1'b1;
        step();
        reset = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hA;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'hB;
        for (int i = 0; i < 4; i++) begin
            logic exp0;
            logic [AW-1:0] exp_addr;
            logic [WIDTH-1:0] exp_data;
            exp0     = (i % 2 == 0);
            exp_addr = exp0 ? 5'd3 : 5'd4;
            exp_data = exp0 ? 32'hA : 32'hB;
            #1;
            checks++;
            if (req0_ready !== exp0 || req1_ready !== !exp0) begin
                errors++;
                $display("[TB] FAIL contention_grant%0d: got r0=%b r1=%b expected %b/%b",
                         i, req0_ready, req1_ready, exp0, !exp0);
            end
            step();
            checks++;
            if (we3 !== 1'b1 || wa3 !== exp_addr || wd3 !== exp_data) begin
                errors++;
                $display("[TB] FAIL contention_write%0d: got we3=%b wa3=%0d wd3=%h expected 1/%0d/%h",
                         i, we3, wa3, wd3, exp_addr, exp_data);
            end
        end
        idle_inputs();
        step();
    endtask

    // A transfer to x0 handshakes but never writes.
    task automatic test_x0();
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL x0_ready: got r0=%b r1=%b expected 0/1", req0_ready, req1_ready);
        end
        step();
        req1_valid = 1'b0;
        checks++;
        if (we3 !== 1'b0) begin errors++; $display("[TB] FAIL x0_we3: got %b expected 0", we3); end
        step();
    endtask

    // Claim sets busy; hazard persists through the write cycle, then drops.
    task automatic test_scoreboard();
        claim_valid = 1'b1; claim_addr = 5'd5; ra1 = 5'd5;
        step();
        claim_valid = 1'b0;
        checks++;
        if (hazard !== 1'b1 || busy[5] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sb_claim: got hazard=%b busy5=%b expected 1/1", hazard, busy[5]);
        end
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h55;
        #1;
        checks++;
        if (hazard !== 1'b1 || req0_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sb_xfer: got hazard=%b r0=%b expected 1/1", hazard, req0_ready);
        end
        step();
        req0_valid = 1'b0;
        checks++;
        if (we3 !== 1'b1 || wa3 !== 5'd5 || hazard !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sb_write: got we3=%b wa3=%0d hazard=%b expected 1/5/1", we3, wa3, hazard);
        end
        step();
        checks++;
        if (hazard !== 1'b0 || busy !== 32'h0) begin
            errors++;
            $display("[TB] FAIL sb_clear: got hazard=%b busy=%h expected 0/0", hazard, busy);
        end
        ra1 = '0;
    endtask

    // Claim and write-clear of the same register on one edge: claim wins.
    // A claim of x0 never sets busy[0].
    task automatic test_collision();
        claim_valid = 1'b1; claim_addr = 5'd6;
        step();
        claim_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h66;
        step();
        req0_valid = 1'b0;
        claim_valid = 1'b1; claim_addr = 5'd6;
        checks++;
        if (we3 !== 1'b1 || wa3 !== 5'd6) begin
            errors++;
            $display("[TB] FAIL coll_write: got we3=%b wa3=%0d expected 1/6", we3, wa3);
        end
        step();
        claim_addr = 5'd0;
        checks++;
        if (busy[6] !== 1'b1) begin errors++; $display("[TB] FAIL coll_busy6: got %b expected 1", busy[6]); end
        step();
        claim_valid = 1'b0;
        ra2 = 5'd6;
        #1;
        checks++;
        if (busy !== 32'h0000_0040 || hazard !== 1'b1) begin
            errors++;
            $display("[TB] FAIL coll_x0claim: got busy=%h hazard=%b expected 00000040/1", busy, hazard);
        end
        ra2 = 5'd0;
        #1;
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL coll_ra0: got %b expected 0", hazard); end
        step();
    endtask

    // Consecutive writes to the same register from different requesters.
    task automatic test_back_to_back();
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h71;
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h72;
        checks++;
        if (we3 !== 1'b1 || wa3 !== 5'd7 || wd3 !== 32'h71) begin
            errors++;
            $display("[TB] FAIL b2b_first: got we3=%b wa3=%0d wd3=%h expected 1/7/71", we3, wa3, wd3);
        end
        step();
        req1_valid = 1'b0;
        checks++;
        if (we3 !== 1'b1 || wa3 !== 5'd7 || wd3 !== 32'h72) begin
            errors++;
            $display("[TB] FAIL b2b_second: got we3=%b wa3=%0d wd3=%h expected 1/7/72", we3, wa3, wd3);
        end
        step();
    endtask

    // Reset in the middle of a transfer drops it and clears the scoreboard.
    task automatic test_reset_mid();
        claim_valid = 1'b1; claim_addr = 5'd9;
        step();
        claim_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
        reset = 1'b1;
        step();
        reset = 1'b0;
        req0_valid = 1'b0;
        checks++;
        if (we3 !== 1'b0 || busy !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid: got we3=%b busy=%h expected 0/0", we3, busy);
        end
        step();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_x0();
        test_scoreboard();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (we3/wa3/wd3) between two writeback requesters (req0: ALU path, req1: load/multicycle path) using valid/ready handshakes and round-robin arbitration. Holds a per-register pending-write scoreboard so decode can stall on RAW hazards against reads on ra1/ra2. Sits between the execute/memory stages and regfile; its we3/wa3/wd3 outputs connect directly to the regfile write port.

Parameters:
WIDTH, 32, data width of wd3 and requester data
AW, 5, register address width (2**AW registers; x0 hard-wired zero)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has a write pending
req0_addr  input  AW  requester 0 destination register
req0_data  input  WIDTH  requester 0 write data
req0_ready  output  1  requester 0 accepted this cycle
req1_valid  input  1  requester 1 has a write pending
req1_addr  input  AW  requester 1 destination register
req1_data  input  WIDTH  requester 1 write data
req1_ready  output  1  requester 1 accepted this cycle
claim_valid  input  1  decode issues an instruction that will write claim_addr
claim_addr  input  AW  register being claimed
ra1  input  AW  regfile read address 1 (snooped)
ra2  input  AW  regfile read address 2 (snooped)
we3  output  1  regfile write enable
wa3  output  AW  regfile write address
wd3  output  WIDTH  regfile write data
hazard  output  1  busy[ra1] | busy[ra2]; decode stall request
busy  output  2**AW  pending-write scoreboard

Behaviour:
- Reset (reset=1 at edge): we3=0, wa3=0, wd3=0, busy=0, last_grant=1 (req0 wins first tie). reset overrides all other events that cycle.
- Arbitration (combinational, same cycle): only one valid -> grant it; both valid -> grant the requester != last_grant; none -> no grant. reqN_ready = grant to N. Ready never depends on downstream; the write port always accepts.
- Handshake: transfer when reqN_valid & reqN_ready. Requester must hold addr/data stable while valid and not ready.
- last_grant updates to the granted index on a transfer edge; unchanged on idle cycles.
- Latency: transfer in cycle N -> we3=1, wa3/wd3 = granted addr/data in cycle N+1 (registered). No transfer -> we3=0 next cycle; wa3/wd3 hold last value.
- Transfer to x0: handshake completes, we3 stays 0 in N+1.
- Throughput: one write per cycle; back-to-back grants allowed; with both valid continuously, grants alternate 0,1,0,1.
- Scoreboard: claim_valid & claim_addr!=0 sets busy[claim_addr] at edge. Bit clears at the edge ending the cycle where we3=1 with wa3==that addr (regfile write happens at same edge). Same address set and clear on same edge -> set wins (new claim outstanding). busy[0] always 0.
- hazard is combinational from current busy and ra1/ra2; ra=0 never hazards.
- Two transfers to same register in consecutive cycles both write; the clear from the first is harmless.
- reset mid-operation: pending transfer registered that cycle is dropped (we3=0 next cycle); all busy cleared.

Decomposition:
- Package regfile_pkg: WIDTH/AW constants, NUM_REGS=2**AW, typedef reg_addr_t (logic [AW-1:0]), typedef word_t (logic [WIDTH-1:0]).
- Sub-module rr_arb2: 2-way round-robin arbiter (valid[1:0], last_grant in -> grant[1:0]); scoreboard and output register stay in top.

Test Plan:
- Reset: hold reset 2 cycles with both valids high -> we3=0, wa3=0, wd3=0, busy=0, no ready while reset asserted affects state.
- Single requester: req0 addr=2 data=32'h15 valid one cycle -> req0_ready=1 same cycle; next cycle we3=1, wa3=2, wd3=32'h15; following cycle we3=0.
- Contention: both valid continuously (req0 addr=3 data=32'hA, req1 addr=4 data=32'hB) after reset -> grants 0,1,0,1; we3 writes alternate wa3=3/4 every cycle.
- x0 write: req1 addr=0 data=32'hFFFF_FFFF -> req1_ready=1; next cycle we3=0.
- Scoreboard: claim addr=5; ra1=5 -> hazard=1 next cycle; req0 writes addr=5 -> hazard stays 1 through the we3=1 cycle, drops to 0 the cycle after.
- Set/clear collision: we3=1 wa3=6 while claim_valid addr=6 same cycle -> busy[6] remains 1; busy[0] never set by claim addr=0.
